// File: rtl/teleferico_pkg.sv
// Shared types for the two-cabin cable car controller: FSM states, alarm causes, sizing helper.
package teleferico_pkg;

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        SAINDO   = 3'd1,
        NORMAL   = 3'd2,
        CHEGANDO = 3'd3,
        ALARME   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALM_NONE     = 3'd0,
        ALM_SENSOR   = 3'd1,
        ALM_T_DEPART = 3'd2,
        ALM_T_CRUISE = 3'd3,
        ALM_T_ARRIVE = 3'd4,
        ALM_EMERG    = 3'd5
    } alarm_code_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/teleferico_ctrl_tick_divider.sv
// Free-running divider; tick is high for the one clk_2 cycle the counter is all-ones.
module tick_divider #(
    parameter int unsigned DIV_BITS = 25
) (
    input  logic clk_2,
    input  logic reset,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt;

    always_ff @(posedge clk_2) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt + DIV_BITS'(1);
    end

    assign tick = &cnt;

endmodule

// File: rtl/teleferico_ctrl.sv
// Two-cabin cable car controller: tick-gated depart/cruise/arrive FSM with timeouts, coded alarms, trip counter.
// Optional emergency stop input enabled by defining TELEF_EMERG_EN.
module teleferico_ctrl
    import teleferico_pkg::*;
#(
    parameter int unsigned DIV_BITS = 25,
    parameter int unsigned T_DEPART = 3,
    parameter int unsigned T_CRUISE = 5,
    parameter int unsigned T_ARRIVE = 3,
    parameter int unsigned TRIP_W   = 8
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              a_pronta,
    input  logic              b_pronta,
    input  logic              perto_base,
    input  logic              perto_topo,
    input  logic              chegou_base,
    input  logic              chegou_topo,
    input  logic              limpar,
`ifdef TELEF_EMERG_EN
    input  logic              emerg,
`endif
    output logic              subir_a,
    output logic              subir_b,
    output logic              lento,
    output logic              alarme,
    output logic [2:0]        alarm_code,
    output logic              a_topo,
    output logic [TRIP_W-1:0] viagens,
    output logic              tick
);

    localparam int unsigned T_MAX = max3(T_DEPART, T_CRUISE, T_ARRIVE);
    localparam int unsigned TMR_W = $clog2(T_MAX) + 1;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             parked;
    logic             emerg_hit;
    logic             clear_ok;

    tick_divider #(.DIV_BITS(DIV_BITS)) u_div (
        .clk_2 (clk_2),
        .reset (reset),
        .tick  (tick)
    );

    assign parked = chegou_base && chegou_topo;

`ifdef TELEF_EMERG_EN
    assign emerg_hit = emerg && (state != ALARME);
    assign clear_ok  = limpar && parked && !emerg;
`else
    assign emerg_hit = 1'b0;
    assign clear_ok  = limpar && parked;
`endif

    // Emergency acts on any edge; everything else waits for the divider tick.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state      <= PARADO;
            timer      <= '0;
            subir_a    <= 1'b0;
            subir_b    <= 1'b0;
            lento      <= 1'b1;
            alarme     <= 1'b0;
            alarm_code <= ALM_NONE;
            a_topo     <= 1'b1;
            viagens    <= '0;
        end else if (emerg_hit) begin
            state <= ALARME; alarme <= 1'b1; alarm_code <= ALM_EMERG;
            subir_a <= 1'b0; subir_b <= 1'b0; lento <= 1'b1;
        end else if (tick) begin
            case (state)
                PARADO: begin
                    if (!parked) begin
                        state <= ALARME; alarme <= 1'b1; alarm_code <= ALM_SENSOR;
                        subir_a <= 1'b0; subir_b <= 1'b0; lento <= 1'b1;
                    end else if (a_pronta && b_pronta) begin
                        state   <= SAINDO;
                        timer   <= TMR_W'(T_DEPART);
                        subir_a <= !a_topo;
                        subir_b <= a_topo;
                    end
                end
                SAINDO: begin
                    if (!perto_base && !perto_topo) begin
                        state <= NORMAL;
                        timer <= TMR_W'(T_CRUISE);
                        lento <= 1'b0;
                    end else if (timer == TMR_W'(1)) begin
                        state <= ALARME; alarme <= 1'b1; alarm_code <= ALM_T_DEPART;
                        subir_a <= 1'b0; subir_b <= 1'b0; lento <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                NORMAL: begin
                    if (perto_base && perto_topo) begin
                        state <= CHEGANDO;
                        timer <= TMR_W'(T_ARRIVE);
                        lento <= 1'b1;
                    end else if (timer == TMR_W'(1)) begin
                        state <= ALARME; alarme <= 1'b1; alarm_code <= ALM_T_CRUISE;
                        subir_a <= 1'b0; subir_b <= 1'b0; lento <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                CHEGANDO: begin
                    if (parked) begin
                        state   <= PARADO;
                        a_topo  <= !a_topo;
                        viagens <= viagens + TRIP_W'(1);
                        subir_a <= 1'b0;
                        subir_b <= 1'b0;
                    end else if (timer == TMR_W'(1)) begin
                        state <= ALARME; alarme <= 1'b1; alarm_code <= ALM_T_ARRIVE;
                        subir_a <= 1'b0; subir_b <= 1'b0; lento <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ALARME: begin
                    if (clear_ok) begin
                        state      <= PARADO;
                        alarme     <= 1'b0;
                        alarm_code <= ALM_NONE;
                    end
                end
                default: begin
                    state <= ALARME; alarme <= 1'b1; alarm_code <= ALM_SENSOR;
                    subir_a <= 1'b0; subir_b <= 1'b0; lento <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/teleferico_ctrl.md
# teleferico_ctrl

Parametrised controller for a two-cabin cable car, where both cabins hang on a single looped haul cable. It sits between the board switches and the motor/alarm indicators. It divides `clk_2` internally into a slow FSM tick. It runs the depart/cruise/arrive cycle with configurable timeouts, alternating travel direction on every trip. Compared with the first-generation controller it adds early state exits, coded alarms, operator alarm clearing and a trip counter.

## Interface
- `DIV_BITS`, default 25: width of the tick divider; must be ≥1.
- `T_DEPART`, default 3: ticks allowed for both cabins to leave proximity; must be ≥1.
- `T_CRUISE`, default 5: ticks allowed at normal speed until both cabins are near again; must be ≥1.
- `T_ARRIVE`, default 3: ticks allowed at slow speed until both cabins are parked; must be ≥1.
- `TRIP_W`, default 8: width of the trip counter.
- `clk_2` in 1 — system clock.
- `reset` in 1 — reset, synchronous, active-high.
- `a_pronta` in 1 — cabin A operator ready.
- `b_pronta` in 1 — cabin B operator ready.
- `perto_base` in 1 — a cabin is near the base station.
- `perto_topo` in 1 — a cabin is near the top station.
- `chegou_base` in 1 — a cabin is parked at the base.
- `chegou_topo` in 1 — a cabin is parked at the top.
- `limpar` in 1 — operator alarm clear.
- `emerg` in 1 — emergency stop; present only with `TELEF_EMERG_EN`.
- `subir_a` out 1 — motor running, A rising / B descending.
- `subir_b` out 1 — motor running, B rising / A descending.
- `lento` out 1 — motor in slow gear.
- `alarme` out 1 — alarm active.
- `alarm_code` out 3 — cause of the latched alarm.
- `a_topo` out 1 — cabin A is currently at the top.
- `viagens` out `TRIP_W` — completed trips, wrapping.
- `tick` out 1 — one-cycle FSM strobe, for the display.

## Operation
- **Divider**
  - Free-running `DIV_BITS` counter.
  - `tick`=1 for one `clk_2` cycle when the counter is all-ones.
  - The FSM evaluates only on tick cycles, except for `emerg`.
- **States:** PARADO, SAINDO, NORMAL, CHEGANDO, ALARME.
- **PARADO**
  - `chegou_base`=0 or `chegou_topo`=0 → ALARME, code 1.
  - Else if `a_pronta` and `b_pronta` → SAINDO, timer loaded with `T_DEPART`.
  - Direction is fixed on that transition: `a_topo`=1 → `subir_b`=1, else `subir_a`=1.
- **SAINDO**
  - `perto_base`=0 and `perto_topo`=0 → NORMAL, timer loaded with `T_CRUISE`.
  - Else if timer==1 → ALARME, code 2.
  - Else timer decrements.
- **NORMAL**
  - `perto_base`=1 and `perto_topo`=1 → CHEGANDO, timer loaded with `T_ARRIVE`.
  - Else if timer==1 → ALARME, code 3.
  - Else timer decrements.
- **CHEGANDO**
  - `chegou_base`=1 and `chegou_topo`=1 → PARADO; `a_topo` toggles; `viagens`+1 (wraps); both motor outputs cleared.
  - Else if timer==1 → ALARME, code 4.
  - Else timer decrements.
- **ALARME**
  - Motor outputs are 0; `alarme`=1; `alarm_code` is held.
  - `limpar`=1 with both `chegou_*`=1 on a tick → PARADO, `alarme`=0, `alarm_code`=0.
  - `a_topo` is unchanged by the clear.
- **Per-state outputs**
  - `lento`=0 only in NORMAL; 1 in every other state.
  - The motor runs only in SAINDO, NORMAL and CHEGANDO.
- **Timeout window:** each timed state grants exactly T ticks. The exit condition is checked on each of them. If it is still false on the T-th tick, the FSM goes to ALARME.
- **Timer width:** `$clog2` of the largest T, plus 1.

## Timing
- All outputs are registered and update on the `clk_2` edge of the deciding tick cycle.
- Latency from input to output: at most one tick period plus one cycle.
- **Reset values**
  - `subir_a`=0, `subir_b`=0, `lento`=1, `alarme`=0.
  - `alarm_code`=0, `a_topo`=1, `viagens`=0.
  - State PARADO; divider=0.
- **Priority rules**
  - `reset` overrides everything, including mid-trip; the motor stops on the next edge.
  - An exit condition and a timeout on the same tick: the exit wins.
  - `emerg` and a timeout in the same cycle: code 5.
  - `limpar` without both cabins parked: ignored.
  - Ready inputs during a trip: ignored.
- `viagens` wraps from 2^`TRIP_W`−1 to 0.

## Configuration
- **`TELEF_EMERG_EN` defined:**
  - The `emerg` port exists.
  - `emerg`=1 in any non-ALARME state → ALARME, code 5, on the next `clk_2` edge, not tick-gated.
  - `limpar` is ignored while `emerg`=1.
- **Not defined:** no `emerg` port; code 5 is never produced.

## Structure
- **`teleferico_pkg`:**
  - State enum.
  - Alarm-code enum: NONE=0, SENSOR=1, T_DEPART=2, T_CRUISE=3, T_ARRIVE=4, EMERG=5.
- **Sub-module `tick_divider`:** parameter `DIV_BITS`; ports `clk_2`, `reset`, `tick`.
- The FSM, timer and trip counter stay in `teleferico_ctrl`.

## Test plan
All scenarios use `DIV_BITS`=1, `T_DEPART`=3, `T_CRUISE`=5, `T_ARRIVE`=3.
- **Nominal trip:** both ready with both parked; near sensors drop on tick 1; both near again on tick 2; parked on tick 1 → `subir_b` pulses through the trip, `lento` 1→0→1, `a_topo`=0, `viagens`=1.
- **Second trip:** repeat the nominal trip → `subir_a` is used, `a_topo`=1, `viagens`=2.
- **Depart timeout:** near sensors held at 1 → ALARME on the 3rd tick, code 2, motor 0, `lento`=1.
- **Arrive timeout:** never parked → code 4 on the 3rd tick of CHEGANDO. Then `limpar`=1 with only `chegou_base`=1 → stays in alarm; with both parked → PARADO, code 0.
- **Sensor fault:** `chegou_topo`=0 in PARADO → code 1 on the next tick.
- **Emergency and reset:** `emerg` asserted mid-NORMAL → code 5 on the next edge, no tick needed. `reset` mid-SAINDO → all reset values on the next edge.
